// File: rtl/rv_pkg.sv
// Shared definitions for the RV64 execute stage: datapath widths and ALU op encodings.
package rv_pkg;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OP_AND   = 4'b0010;
    localparam logic [3:0] ALU_OP_OR    = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR   = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL   = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL   = 4'b0110;
    localparam logic [3:0] ALU_OP_SRA   = 4'b0111;
    localparam logic [3:0] ALU_OP_SLT   = 4'b1000;
    localparam logic [3:0] ALU_OP_PASSB = 4'b1001;

endpackage

// File: rtl/ex_alu.sv
// Combinational execute ALU: operand-B mux, op decode, shifters and signed compare.
module ex_alu
    import rv_pkg::*;
#(
    parameter int DATA_W = rv_pkg::DATA_W
) (
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] shl_y;
    logic [DATA_W-1:0] shr_y;
    logic [DATA_W-1:0] sra_y;
    logic              slt;

    assign op_b = use_imm ? imm : rs2;
    assign slt  = $signed(rs1) < $signed(op_b);

    // The shifters are fixed at 64 bits, which is why DATA_W must stay 64.
    shl64 u_shl (.a(rs1), .shamt(op_b[5:0]), .y(shl_y));
    shr64 u_shr (.a(rs1), .shamt(op_b[5:0]), .y(shr_y));
    sra64 u_sra (.a(rs1), .shamt(op_b[5:0]), .y(sra_y));

    always_comb begin
        // NOTE: default first so no path through the case leaves result unassigned (no latch).
        result = '0;
        unique case (alu_op)
            ALU_OP_ADD:   result = rs1 + op_b;
            ALU_OP_SUB:   result = rs1 - op_b;
            ALU_OP_AND:   result = rs1 & op_b;
            ALU_OP_OR:    result = rs1 | op_b;
            ALU_OP_XOR:   result = rs1 ^ op_b;
            ALU_OP_SLL:   result = shl_y;
            ALU_OP_SRL:   result = shr_y;
            ALU_OP_SRA:   result = sra_y;
            ALU_OP_SLT:   result = {{(DATA_W-1){1'b0}}, slt};
            ALU_OP_PASSB: result = op_b;
            default:      result = '0;
        endcase
    end
endmodule

// File: rtl/shl64.sv
// 64-bit logical left shifter.
module shl64 (
    input  logic [63:0] a,
    input  logic [5:0]  shamt,
    output logic [63:0] y
);
    assign y = a << shamt;
endmodule

// File: rtl/shr64.sv
// 64-bit logical right shifter (zero fill).
module shr64 (
    input  logic [63:0] a,
    input  logic [5:0]  shamt,
    output logic [63:0] y
);
    assign y = a >> shamt;
endmodule

// File: rtl/sra64.sv
// 64-bit arithmetic right shifter (sign fill).
module sra64 (
    input  logic [63:0] a,
    input  logic [5:0]  shamt,
    output logic [63:0] y
);
    assign y = $unsigned($signed(a) >>> shamt);
endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: ALU, BEQ evaluation and the EX/MEM pipeline register with reset > flush > stall > load.
module ex_mem_stage
    import rv_pkg::*;
#(
    parameter int DATA_W = rv_pkg::DATA_W,
    parameter int REG_AW = rv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs1,
    input  logic [DATA_W-1:0] id_rs2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_br_taken,
    output logic [DATA_W-1:0] ex_br_target
);
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] br_target;
    logic              br_cond;

    ex_alu #(.DATA_W(DATA_W)) u_alu (
        .alu_op  (id_alu_op),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .imm     (id_imm),
        .use_imm (id_use_imm),
        .result  (alu_result)
    );

    // BEQ always compares the two registers, never the immediate.
    assign br_cond   = id_branch & id_valid & (id_rs1 == id_rs2);
    assign br_target = id_pc + (id_imm << 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            ex_valid      <= 1'b0;
            ex_result     <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_br_taken   <= 1'b0;
            ex_br_target  <= '0;
        end else if (flush) begin
            // Bubble: kill the control bits, data fields are don't-care while invalid.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_br_taken  <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid;
            ex_result     <= alu_result;
            ex_store_data <= id_rs2;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_br_taken   <= br_cond;
            ex_br_target  <= br_target;
        end
    end
endmodule
